food_count_scanner: RTL and testbench

- Reads the food map, the opposite direction to the eaten-food flush writer that clears bits in the map.
- Sweeps every row through the map's read port, popcounts each row and reports the remaining food count.
- Reports food eaten since the previous sweep and accumulates a score.
- Flags level clear when no food remains. Sits between the food map memory and the game-state / scoreboard logic.

---
 rtl/food_count_scanner.sv | 165 ++++++++++++++++
 tb/tb_food_count_scanner.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/food_count_scanner.sv
// Sweeps the food map one row per cycle, popcounts each row and commits the remaining food count, eaten pulse and score.
// Optional build macro FOOD_SCAN_AUTO_EN makes sweeps free-run back-to-back and ignore start.
module food_count_scanner #(
  parameter int ROWS         = 50,
  parameter int COLS         = 80,
  parameter int ADDR_W       = 6,
  parameter int CNT_W        = 12,
  parameter int READ_LATENCY = 1,
  parameter int POINTS       = 10,
  parameter int SCORE_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [ADDR_W-1:0]  food_map_read_y,
  input  logic [COLS-1:0]    food_row,
  output logic               busy,
  output logic [CNT_W-1:0]   food_count,
  output logic               count_valid,
  output logic               level_clear,
  output logic               eaten_pulse,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DW    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam int PW    = $clog2(POINTS + 1);
  localparam int SUM_W = ((SCORE_W > CNT_W + PW) ? SCORE_W : CNT_W + PW) + 1;

  localparam logic [ADDR_W-1:0] LAST_ROW   = ADDR_W'(ROWS - 1);
  localparam logic [DW-1:0]     LAST_DRAIN = DW'(READ_LATENCY - 1);
  localparam logic [SUM_W-1:0]  SCORE_MAX  = SUM_W'({SCORE_W{1'b1}});

  state_t                  state, state_nxt;
  logic [ADDR_W-1:0]       row_q, row_nxt;
  logic [DW-1:0]           drain_q, drain_nxt;
  logic [READ_LATENCY-1:0] vld_pipe;
  logic [CNT_W-1:0]        acc;
  logic                    sweep_begin;
  logic                    row_vld;
  logic [CNT_W-1:0]        row_pop;
  logic [CNT_W-1:0]        eaten_cnt;
  logic [SUM_W-1:0]        score_sum;
  logic [SCORE_W-1:0]      score_next;

  function automatic logic [CNT_W-1:0] popcount(input logic [COLS-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < COLS; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  // start is a level-sampled request: it is honoured only on a clock edge
  // where the FSM is IDLE; there is no ready/ack, and requests while busy
  // (including the DONE cycle) are dropped, never queued.
  always_comb begin
    state_nxt = state;
    row_nxt   = row_q;
    drain_nxt = drain_q;
    case (state)
      IDLE: begin
        row_nxt = '0;
`ifdef FOOD_SCAN_AUTO_EN
        state_nxt = SCAN;
`else
        if (start) state_nxt = SCAN;
`endif
      end
      SCAN: begin
        if (row_q == LAST_ROW) begin
          state_nxt = DRAIN;
          drain_nxt = '0;
        end else begin
          row_nxt = row_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q == LAST_DRAIN) state_nxt = DONE;
        else drain_nxt = drain_q + 1'b1;
      end
      DONE: begin
        row_nxt = '0;
`ifdef FOOD_SCAN_AUTO_EN
        state_nxt = SCAN;
`else
        state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef FOOD_SCAN_AUTO_EN
  logic unused_start;
  assign unused_start = start;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      row_q   <= '0;
      drain_q <= '0;
    end else begin
      state   <= state_nxt;
      row_q   <= row_nxt;
      drain_q <= drain_nxt;
    end
  end

  assign sweep_begin = (state_nxt == SCAN) && (state != SCAN);
  assign row_vld     = vld_pipe[READ_LATENCY-1];
  assign row_pop     = popcount(food_row);

  // One valid bit per issued address; it lines up with food_row READ_LATENCY cycles later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      acc      <= '0;
    end else begin
      vld_pipe <= (vld_pipe << 1) | READ_LATENCY'(state == SCAN);
      if (sweep_begin) acc <= '0;
      else if (row_vld) acc <= acc + row_pop;
    end
  end

  // Score increment for food eaten since the last sweep, saturating.
  always_comb begin
    eaten_cnt  = food_count - acc;
    score_sum  = SUM_W'(score) + SUM_W'(eaten_cnt) * SUM_W'(POINTS);
    score_next = (score_sum > SCORE_MAX) ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      food_count  <= '0;
      count_valid <= 1'b0;
      level_clear <= 1'b0;
      eaten_pulse <= 1'b0;
      score       <= '0;
    end else begin
      eaten_pulse <= 1'b0;
      if (state == DONE) begin
        food_count  <= acc;
        count_valid <= 1'b1;
        level_clear <= (acc == '0);
        if (count_valid && (acc < food_count)) begin
          eaten_pulse <= 1'b1;
          score       <= score_next;
        end
      end
    end
  end

  assign food_map_read_y = row_q;
  assign busy            = (state != IDLE);
  assign state_dbg       = state;

endmodule

// File: tb/tb_food_count_scanner.sv
// Randomised scoreboard bench for food_count_scanner: a map/score reference model queues expected sweep results, a monitor checks each completed sweep.
module tb_food_count_scanner;

  localparam int ROWS         = 50;
  localparam int COLS         = 80;
  localparam int ADDR_W       = 6;
  localparam int CNT_W        = 12;
  localparam int READ_LATENCY = 1;
  localparam int POINTS       = 10;
  localparam int SCORE_W      = 16;
  localparam int W            = CNT_W + SCORE_W + 3;
  localparam int SMAX         = (1 << SCORE_W) - 1;
  localparam int SWEEP_CYC    = ROWS + READ_LATENCY + 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [ADDR_W-1:0]  read_y;
  logic [COLS-1:0]    food_row;
  logic               busy;
  logic [CNT_W-1:0]   food_count;
  logic               count_valid;
  logic               level_clear;
  logic               eaten_pulse;
  logic [SCORE_W-1:0] score;
  logic [1:0]         state_dbg;

  food_count_scanner #(
    .ROWS(ROWS), .COLS(COLS), .ADDR_W(ADDR_W), .CNT_W(CNT_W),
    .READ_LATENCY(READ_LATENCY), .POINTS(POINTS), .SCORE_W(SCORE_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .food_map_read_y(read_y),
    .food_row(food_row), .busy(busy), .food_count(food_count),
    .count_valid(count_valid), .level_clear(level_clear),
    .eaten_pulse(eaten_pulse), .score(score), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- food map memory model ----------------
  logic [COLS-1:0] mem     [ROWS];
  logic [COLS-1:0] rd_pipe [READ_LATENCY];

  always @(posedge clk) begin
    rd_pipe[0] <= (int'(read_y) < ROWS) ? mem[read_y] : '0;
    for (int i = 1; i < READ_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign food_row = rd_pipe[READ_LATENCY-1];

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  int m_prev  = 0;
  bit m_valid = 0;
  int m_score = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int map_count();
    int c = 0;
    for (int r = 0; r < ROWS; r++) c += $countones(mem[r]);
    return c;
  endfunction

  function automatic logic [COLS-1:0] rand_row();
    logic [95:0] v;
    v = {$urandom(), $urandom(), $urandom()};
    return v[COLS-1:0];
  endfunction

  task automatic push_expect();
    int cnt;
    bit eat;
    cnt = map_count();
    eat = 0;
    if (m_valid && cnt < m_prev) begin
      eat = 1;
      m_score = m_score + (m_prev - cnt) * POINTS;
      if (m_score > SMAX) m_score = SMAX;
    end
    m_prev  = cnt;
    m_valid = 1;
    exp_q.push_back({(cnt == 0), eat, SCORE_W'(m_score), CNT_W'(cnt), 1'b1});
  endtask

  // ---------------- monitor ----------------
  bit busy_prev   = 0;
  bit pulse_chk   = 0;
  int busy_cycles = 0;
  int addr_err    = 0;

  always @(negedge clk) begin
    logic [W-1:0] e;
    int exp_addr;
    if (rst) begin
      busy_prev   = 0;
      pulse_chk   = 0;
      busy_cycles = 0;
      addr_err    = 0;
    end else begin
      if (pulse_chk) begin
        check("pulse_width", eaten_pulse, 0);
        pulse_chk = 0;
      end else if (!(busy_prev && !busy) && eaten_pulse) begin
        check("stray_pulse", eaten_pulse, 0);
      end
      if (busy) begin
        if (!busy_prev) begin
          busy_cycles = 0;
          addr_err    = 0;
        end
        if (busy_cycles < ROWS + READ_LATENCY) begin
          exp_addr = (busy_cycles < ROWS) ? busy_cycles : ROWS - 1;
          if (int'(read_y) != exp_addr) addr_err++;
        end
        busy_cycles++;
      end else if (busy_prev) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: sweep completed with nothing expected at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("food_count",  food_count,  e[CNT_W:1]);
          check("count_valid", count_valid, e[0]);
          check("score",       score,       e[CNT_W+SCORE_W:CNT_W+1]);
          check("eaten_pulse", eaten_pulse, e[W-2]);
          check("level_clear", level_clear, e[W-1]);
          check("busy_len",    busy_cycles, SWEEP_CYC);
          check("addr_seq",    addr_err,    0);
        end
        pulse_chk = 1;
      end
      busy_prev = busy;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    while (exp_q.size() != 0 && k < 4 * SWEEP_CYC) begin
      @(posedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sweep_timeout: no completion within %0d cycles", k);
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic run_sweep();
    push_expect();
    pulse_start();
    wait_done();
  endtask

  // Second start pulse issued during cycle t0+at of a running sweep.
  task automatic run_sweep_extra_start(input int at);
    push_expect();
    pulse_start();
    repeat (at - 1) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("no_requeue_busy", busy, 0);
  endtask

  task automatic clear_map();
    for (int r = 0; r < ROWS; r++) mem[r] = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},        busy,        0);
    check({tag, "_read_y"},      read_y,      0);
    check({tag, "_food_count"},  food_count,  0);
    check({tag, "_count_valid"}, count_valid, 0);
    check({tag, "_level_clear"}, level_clear, 0);
    check({tag, "_eaten_pulse"}, eaten_pulse, 0);
    check({tag, "_score"},       score,       0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r;
    logic [COLS-1:0] m;
    rst   = 1'b1;
    start = 1'b0;
    clear_map();
    for (int i = 0; i < READ_LATENCY; i++) rd_pipe[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // empty map: level clear on first sweep
    run_sweep();

    // 81 cells, first real count
    mem[3]  = '1;
    mem[49] = COLS'(1);
    run_sweep();

    // eat 5 cells of row 3
    mem[3][4:0] = 5'b0;
    run_sweep();
    run_sweep();

    // reload to 120 cells
    clear_map();
    mem[10] = '1;
    mem[20] = {{(COLS-40){1'b0}}, {40{1'b1}}};
    run_sweep();

    // start retriggered during scan and during DONE
    mem[20][0] = 1'b0;
    run_sweep_extra_start(10);
    mem[10][7] = 1'b0;
    run_sweep_extra_start(SWEEP_CYC);

    // randomised eat / reload / idle sweeps
    for (int it = 0; it < 14; it++) begin
      case ($urandom_range(0, 3))
        0, 1: begin
          repeat ($urandom_range(1, 4)) begin
            r = $urandom_range(0, ROWS - 1);
            m = rand_row();
            mem[r] = mem[r] & m;
          end
        end
        2: for (int k = 0; k < ROWS; k++) mem[k] = rand_row() & rand_row();
        default: ;
      endcase
      run_sweep();
    end

    // score saturation: full -> empty twice
    for (int k = 0; k < ROWS; k++) mem[k] = '1;
    run_sweep();
    clear_map();
    run_sweep();
    for (int k = 0; k < ROWS; k++) mem[k] = '1;
    run_sweep();
    clear_map();
    run_sweep();
    run_sweep();

    // reset mid-sweep, then first sweep again
    mem[3]  = '1;
    mem[49] = COLS'(1);
    pulse_start();
    repeat (24) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_all_zero("midreset");
    exp_q.delete();
    m_prev  = 0;
    m_valid = 0;
    m_score = 0;
    @(posedge clk); #1 rst = 1'b0;
    run_sweep();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
